// File: rtl/multichannel_decimator.sv
`default_nettype none
// ============================================================================
// Module      : multichannel_decimator
// Description : Multichannel decimating boxcar accumulator. Interleaved,
//               channel-tagged samples arrive on a valid/ready stream. Each
//               channel sums DECIMATION samples and emits either the exact
//               sum or the arithmetic-shift mean on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module multichannel_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CHANNELS = 4,
  parameter int DECIMATION = 8,
  parameter int MEAN_MODE  = 0,
  localparam int CH_WIDTH  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int CNT_WIDTH = $clog2(DECIMATION),
  localparam int ACC_WIDTH = DATA_WIDTH + CNT_WIDTH,
  localparam int OUT_WIDTH = (MEAN_MODE != 0) ? DATA_WIDTH : ACC_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic        [CH_WIDTH-1:0]   in_dest,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic        [CH_WIDTH-1:0]   out_dest,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         dest_error
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if (N_CHANNELS < 1) begin : g_bad_channels
    $error("multichannel_decimator: N_CHANNELS must be >= 1");
  end

  if (DECIMATION < 2) begin : g_bad_decimation
    $error("multichannel_decimator: DECIMATION must be >= 2");
  end

  // The mean is a plain arithmetic shift, so it is only exact for powers of two.
  if ((MEAN_MODE != 0) && ((DECIMATION & (DECIMATION - 1)) != 0)) begin : g_bad_mean
    $error("multichannel_decimator: MEAN_MODE requires a power-of-two DECIMATION");
  end

  // --------------------------------------------------------------------------
  // Per-channel state
  // --------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] acc [N_CHANNELS];
  logic        [CNT_WIDTH-1:0] cnt [N_CHANNELS];

  logic                        accept;
  logic                        dest_ok;
  logic                        last;
  logic                        complete;
  logic signed [ACC_WIDTH-1:0] sel_acc;
  logic        [CNT_WIDTH-1:0] sel_cnt;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [OUT_WIDTH-1:0] result;

  // A held output blocks the input; a consumed or empty output slot frees it.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // When the channel count fills the id space every id is legal; otherwise
  // ids at or above N_CHANNELS are flagged and dropped.
  if (N_CHANNELS == (1 << CH_WIDTH)) begin : g_dest_full
    assign dest_ok = 1'b1;
  end else begin : g_dest_partial
    assign dest_ok = (in_dest < CH_WIDTH'(N_CHANNELS));
  end

  // Select the addressed channel's accumulator and count (zero if none matches).
  always_comb begin
    sel_acc = '0;
    sel_cnt = '0;
    for (int ch = 0; ch < N_CHANNELS; ch++) begin
      if (in_dest == CH_WIDTH'(ch)) begin
        sel_acc = acc[ch];
        sel_cnt = cnt[ch];
      end
    end
  end

  // Running sum including the incoming sample; ACC_WIDTH is wide enough for
  // DECIMATION full-scale samples so this never wraps.
  assign sum      = sel_acc + {{CNT_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
  assign last     = (sel_cnt == CNT_WIDTH'(DECIMATION - 1));
  assign complete = accept && dest_ok && last;

  // Output value: exact sum, or arithmetic right shift (rounds toward -inf).
  if (MEAN_MODE != 0) begin : g_mean
    assign result = OUT_WIDTH'(sum >>> CNT_WIDTH);
  end else begin : g_sum
    assign result = sum;
  end

  // Accumulate accepted samples into their channel; clear on completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int ch = 0; ch < N_CHANNELS; ch++) begin
        acc[ch] <= '0;
        cnt[ch] <= '0;
      end
    end else if (accept && dest_ok) begin
      for (int ch = 0; ch < N_CHANNELS; ch++) begin
        if (in_dest == CH_WIDTH'(ch)) begin
          if (last) begin
            acc[ch] <= '0;
            cnt[ch] <= '0;
          end else begin
            acc[ch] <= sum;
            cnt[ch] <= cnt[ch] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Output register: load on completion (also back-to-back), drop when consumed.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_dest   <= '0;
      dest_error <= 1'b0;
    end else begin
      dest_error <= accept && !dest_ok;
      if (complete) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_dest  <= in_dest;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multichannel_decimator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_multichannel_decimator
// Description : Directed self-checking bench. Three instances share the
//               sample/dest buses: A = defaults (sum), B = mean mode,
//               C = three channels (invalid-dest handling).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multichannel_decimator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  logic signed [15:0] in_data;
  logic        [1:0]  in_dest;
  logic        [2:0]  vld;
  logic        [2:0]  ordy;
  wire         [2:0]  irdy;

  wire signed [18:0] a_data;
  wire        [1:0]  a_dest;
  wire               a_valid, a_err;
  wire signed [15:0] b_data;
  wire        [1:0]  b_dest;
  wire               b_valid, b_err;
  wire signed [18:0] c_data;
  wire        [1:0]  c_dest;
  wire               c_valid, c_err;

  int n_cmp = 0;
  int n_bad = 0;

  multichannel_decimator dut_a (
    .clock(clock), .reset(reset), .in_data(in_data), .in_dest(in_dest),
    .in_valid(vld[0]), .in_ready(irdy[0]), .out_data(a_data), .out_dest(a_dest),
    .out_valid(a_valid), .out_ready(ordy[0]), .dest_error(a_err)
  );

  multichannel_decimator #(.MEAN_MODE(1)) dut_b (
    .clock(clock), .reset(reset), .in_data(in_data), .in_dest(in_dest),
    .in_valid(vld[1]), .in_ready(irdy[1]), .out_data(b_data), .out_dest(b_dest),
    .out_valid(b_valid), .out_ready(ordy[1]), .dest_error(b_err)
  );

  multichannel_decimator #(.N_CHANNELS(3)) dut_c (
    .clock(clock), .reset(reset), .in_data(in_data), .in_dest(in_dest),
    .in_valid(vld[2]), .in_ready(irdy[2]), .out_data(c_data), .out_dest(c_dest),
    .out_valid(c_valid), .out_ready(ordy[2]), .dest_error(c_err)
  );

  // Count one comparison and report it if the observed value differs.
  task automatic check_value(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample to instance sel and return 1 ns after it is accepted.
  task automatic send(input int sel, input logic [1:0] d, input logic signed [15:0] x);
    int guard;
    @(negedge clock);
    in_dest  = d;
    in_data  = x;
    vld[sel] = 1'b1;
    guard    = 0;
    while (irdy[sel] !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) check_value("send_ready_timeout", irdy[sel], 1);
    @(posedge clock);
    #1;
    vld[sel] = 1'b0;
  endtask

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    vld     = '0;
    ordy    = 3'b111;
    in_data = '0;
    in_dest = '0;
    repeat (3) @(posedge clock);
    #1;
    check_value("rst_valid", a_valid, 0);
    check_value("rst_data",  a_data,  0);
    check_value("rst_dest",  a_dest,  0);
    check_value("rst_err",   a_err,   0);
    check_value("rst_ready", irdy[0], 1);
    @(negedge clock);
    reset = 1'b0;

    // T1: ch0 1..8 -> 36, valid one cycle after the 8th accept.
    for (int i = 1; i <= 7; i++) send(0, 2'd0, 16'(i));
    check_value("t1_not_early", a_valid, 0);
    send(0, 2'd0, 16'sd8);
    check_value("t1_valid", a_valid, 1);
    check_value("t1_data",  a_data,  36);
    check_value("t1_dest",  a_dest,  0);
    @(posedge clock); #1;
    check_value("t1_drop", a_valid, 0);

    // T2: ch1 100 / ch2 -5 alternated -> 800 then -40 back-to-back.
    for (int i = 0; i < 8; i++) begin
      send(0, 2'd1, 16'sd100);
      if (i == 7) begin
        check_value("t2_valid1", a_valid, 1);
        check_value("t2_data1",  a_data,  800);
        check_value("t2_dest1",  a_dest,  1);
      end
      send(0, 2'd2, -16'sd5);
    end
    check_value("t2_valid2", a_valid, 1);
    check_value("t2_data2",  a_data,  -40);
    check_value("t2_dest2",  a_dest,  2);
    @(posedge clock); #1;
    check_value("t2_drop", a_valid, 0);

    // T3: mean mode.
    for (int i = 0; i < 8; i++) send(1, 2'd3, -16'sd3);
    check_value("t3_valid_a", b_valid, 1);
    check_value("t3_mean_a",  b_data,  -3);
    check_value("t3_dest_a",  b_dest,  3);
    for (int i = 0; i < 7; i++) send(1, 2'd0, 16'sd1);
    send(1, 2'd0, 16'sd0);
    check_value("t3_mean_b", b_data, 0);
    check_value("t3_dest_b", b_dest, 0);
    for (int i = 0; i < 7; i++) send(1, 2'd1, 16'sd0);
    send(1, 2'd1, -16'sd1);
    check_value("t3_mean_neg", b_data, -1);
    check_value("t3_dest_neg", b_dest, 1);

    // T4: backpressure with a completion pending behind the held output.
    @(negedge clock);
    ordy[0] = 1'b0;
    for (int i = 0; i < 7; i++) send(0, 2'd1, 16'sd3);
    for (int i = 0; i < 8; i++) send(0, 2'd0, 16'sd10);
    check_value("t4_valid", a_valid, 1);
    check_value("t4_data",  a_data,  80);
    check_value("t4_ready", irdy[0], 0);
    @(negedge clock);
    in_dest = 2'd1;
    in_data = 16'sd3;
    vld[0]  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check_value("t4_hold_data",  a_data,  80);
      check_value("t4_hold_dest",  a_dest,  0);
      check_value("t4_hold_ready", irdy[0], 0);
    end
    @(negedge clock);
    ordy[0] = 1'b1;
    @(posedge clock); #1;
    vld[0] = 1'b0;
    check_value("t4_b2b_valid", a_valid, 1);
    check_value("t4_b2b_data",  a_data,  24);
    check_value("t4_b2b_dest",  a_dest,  1);
    @(posedge clock); #1;
    check_value("t4_drop", a_valid, 0);

    // T5: full-scale extremes.
    for (int i = 0; i < 8; i++) send(0, 2'd2, 16'sh7FFF);
    check_value("t5_max", a_data, 262136);
    for (int i = 0; i < 8; i++) send(0, 2'd3, -16'sd32768);
    check_value("t5_min", a_data, -262144);
    check_value("t5_dest", a_dest, 3);

    // T6: partial sum discarded by a mid-stream reset.
    for (int i = 0; i < 5; i++) send(0, 2'd0, 16'sd7);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_value("t6_rst_data",  a_data,  0);
    check_value("t6_rst_valid", a_valid, 0);
    for (int i = 0; i < 7; i++) send(0, 2'd0, 16'sd2);
    check_value("t6_not_early", a_valid, 0);
    send(0, 2'd0, 16'sd2);
    check_value("t6_data", a_data, 16);
    check_value("t6_dest", a_dest, 0);

    // T7: three channels, dest 3 is invalid and must not disturb ch2.
    for (int i = 0; i < 7; i++) send(2, 2'd2, 16'sd1);
    check_value("t7_err_idle", c_err, 0);
    send(2, 2'd3, 16'sd50);
    check_value("t7_err_pulse", c_err,   1);
    check_value("t7_no_out",    c_valid, 0);
    @(posedge clock); #1;
    check_value("t7_err_clear", c_err, 0);
    send(2, 2'd2, 16'sd1);
    check_value("t7_valid", c_valid, 1);
    check_value("t7_data",  c_data,  8);
    check_value("t7_dest",  c_dest,  2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
